// File: rtl/router_sync_nport.sv
// router_sync_nport: synchroniser between the router FSM/register block and
// NUM_PORTS output FIFOs.
//   clock, resetn           : rising-edge clock, synchronous active-low reset
//   detect_add, data_in     : header strobe and destination address to latch
//   write_enb_reg           : FSM request to write the current byte
//   read_enb, empty, full   : per-port FIFO status from the output side
//   vld_out                 : per-port data valid (~empty), combinational
//   write_enb               : registered one-hot FIFO write enable
//   fifo_full               : registered full flag of the addressed FIFO
//   soft_reset              : registered one-cycle pulse per stalled FIFO
//   addr_err                : registered one-cycle pulse on out-of-range header

// Per-port stall timer. It counts edges where the port holds data that is not
// being read. It fires a single-cycle pulse on the TIMEOUT-th consecutive
// stalled edge and then starts a fresh window.
module router_sync_tmr #(
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 5
) (
  input  logic clock,
  input  logic resetn,
  input  logic vld,
  input  logic rd,
  output logic soft_reset
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end else if (!vld || rd) begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      cnt        <= '0;
      soft_reset <= 1'b1;
    end else begin
      cnt        <= cnt + 1'b1;
      soft_reset <= 1'b0;
    end
  end
endmodule

module router_sync_nport #(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_W    = 2,
  parameter int TIMEOUT   = 30,
  parameter int CNT_W     = 5
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 detect_add,
  input  logic [ADDR_W-1:0]    data_in,
  input  logic                 write_enb_reg,
  input  logic [NUM_PORTS-1:0] read_enb,
  input  logic [NUM_PORTS-1:0] empty,
  input  logic [NUM_PORTS-1:0] full,
  output logic [NUM_PORTS-1:0] vld_out,
  output logic [NUM_PORTS-1:0] write_enb,
  output logic                 fifo_full,
  output logic [NUM_PORTS-1:0] soft_reset,
  output logic                 addr_err
);
  // One extra bit so NUM_PORTS == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] NP_EXT = (ADDR_W + 1)'(NUM_PORTS);

  logic [ADDR_W-1:0]    addr_q;
  logic [NUM_PORTS-1:0] addr_dec;
  logic                 addr_bad;

  // One-hot decode of the latched address. An out-of-range address matches no
  // port, so it gives write_enb = 0 and fifo_full = 0 without an extra compare.
  always_comb begin
    addr_dec = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      addr_dec[i] = (addr_q == ADDR_W'(i));
  end

  assign addr_bad = detect_add && ({1'b0, data_in} >= NP_EXT);
  assign vld_out  = ~empty;

  // Outputs decode addr_q as it stood before this edge. A new header is
  // therefore used from the following edge onward.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      addr_q    <= '0;
      write_enb <= '0;
      fifo_full <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      if (detect_add) addr_q <= data_in;
      write_enb <= write_enb_reg ? addr_dec : '0;
      fifo_full <= |(full & addr_dec);
      addr_err  <= addr_bad;
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    router_sync_tmr #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_tmr (
      .clock      (clock),
      .resetn     (resetn),
      .vld        (vld_out[g]),
      .rd         (read_enb[g]),
      .soft_reset (soft_reset[g])
    );
  end
endmodule

// File: tb/tb_router_sync_nport.sv
// Testbench for router_sync_nport. Two instances: 3 ports / TIMEOUT 30 and
// 4 ports / TIMEOUT 4. Both are driven by directed phases followed by biased
// random traffic. Both are compared every cycle against a reference model.
module tb_router_sync_nport;
  int np[2] = '{3, 4};
  int to[2] = '{30, 4};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn;
  logic       da[2], wr[2];
  logic [1:0] di[2];
  logic [7:0] rd[2], em[2], fu[2];

  logic [2:0] vld0, wen0, sr0;
  logic       ff0, err0;
  logic [3:0] vld1, wen1, sr1;
  logic       ff1, err1;

  router_sync_nport #(.NUM_PORTS(3), .ADDR_W(2), .TIMEOUT(30), .CNT_W(5)) u_dut0 (
    .clock(clk), .resetn(rstn), .detect_add(da[0]), .data_in(di[0]),
    .write_enb_reg(wr[0]), .read_enb(rd[0][2:0]), .empty(em[0][2:0]),
    .full(fu[0][2:0]), .vld_out(vld0), .write_enb(wen0), .fifo_full(ff0),
    .soft_reset(sr0), .addr_err(err0));

  router_sync_nport #(.NUM_PORTS(4), .ADDR_W(2), .TIMEOUT(4), .CNT_W(2)) u_dut1 (
    .clock(clk), .resetn(rstn), .detect_add(da[1]), .data_in(di[1]),
    .write_enb_reg(wr[1]), .read_enb(rd[1][3:0]), .empty(em[1][3:0]),
    .full(fu[1][3:0]), .vld_out(vld1), .write_enb(wen1), .fifo_full(ff1),
    .soft_reset(sr1), .addr_err(err1));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model. The address is held as an int. The timeout is tracked
  // as the length of the current unbroken stall: a pulse is due whenever that
  // length is a non-zero multiple of TIMEOUT.
  int         m_addr[2];
  int         run[2][8];
  logic [7:0] e_wen[2], e_sr[2];
  logic       e_ff[2], e_err[2];

  task automatic model_step(int k);
    if (!rstn) begin
      m_addr[k] = 0;
      e_wen[k] = '0; e_sr[k] = '0; e_ff[k] = 1'b0; e_err[k] = 1'b0;
      for (int i = 0; i < 8; i++) run[k][i] = 0;
    end else begin
      e_err[k] = da[k] && (int'(di[k]) >= np[k]);
      e_wen[k] = (wr[k] && m_addr[k] < np[k]) ? 8'(1 << m_addr[k]) : 8'd0;
      e_ff[k]  = (m_addr[k] < np[k]) ? fu[k][m_addr[k]] : 1'b0;
      e_sr[k]  = '0;
      for (int i = 0; i < np[k]; i++) begin
        if (em[k][i] || rd[k][i]) run[k][i] = 0;
        else begin
          run[k][i]++;
          if (run[k][i] % to[k] == 0) e_sr[k][i] = 1'b1;
        end
      end
      if (da[k]) m_addr[k] = int'(di[k]);
    end
  endtask

  task automatic check_regs(int k);
    logic [7:0] w, s;
    logic f, e;
    if (k == 0) begin w = 8'(wen0); s = 8'(sr0); f = ff0; e = err0; end
    else        begin w = 8'(wen1); s = 8'(sr1); f = ff1; e = err1; end
    chk($sformatf("d%0d write_enb", k), 32'(w), 32'(e_wen[k]));
    chk($sformatf("d%0d soft_reset", k), 32'(s), 32'(e_sr[k]));
    chk($sformatf("d%0d fifo_full", k), 32'(f), 32'(e_ff[k]));
    chk($sformatf("d%0d addr_err", k), 32'(e), 32'(e_err[k]));
  endtask

  // Inputs are set at the falling edge. Combinational vld_out is checked
  // first, the model then advances one edge, and the registered outputs are
  // checked at the next falling edge.
  task automatic tick();
    logic [7:0] mask;
    #1;
    for (int k = 0; k < 2; k++) begin
      mask = 8'((1 << np[k]) - 1);
      chk($sformatf("d%0d vld_out", k),
          (k == 0) ? 32'(vld0) : 32'(vld1), 32'(~em[k] & mask));
    end
    for (int k = 0; k < 2; k++) model_step(k);
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) check_regs(k);
  endtask

  task automatic quiet();
    for (int k = 0; k < 2; k++) begin
      da[k] = 1'b0; wr[k] = 1'b0; di[k] = '0;
      rd[k] = '0; em[k] = '1; fu[k] = '0;
    end
  endtask

  // Empty flags toggle rarely and reads are sparse, so stalls run long
  // enough to reach the 30-cycle timeout now and then.
  task automatic rand_inputs(int k);
    da[k] = ($urandom_range(0, 5) == 0);
    di[k] = 2'($urandom_range(0, 3));
    wr[k] = $urandom_range(0, 1) == 1;
    fu[k] = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 39) == 0) em[k][i] = ~em[k][i];
      rd[k][i] = ($urandom_range(0, 34) == 0);
    end
  endtask

  initial begin
    rstn = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rand_inputs(k);
      em[k] = 8'($urandom);
    end
    @(negedge clk);
    // Reset with random inputs: all registered outputs must be 0.
    repeat (2) begin
      for (int k = 0; k < 2; k++) rand_inputs(k);
      tick();
    end
    rstn = 1'b1;
    quiet();
    tick();

    // Header to port 2, then write, drop write, full on port 2.
    for (int k = 0; k < 2; k++) begin da[k] = 1'b1; di[k] = 2'd2; end
    tick();
    for (int k = 0; k < 2; k++) begin da[k] = 1'b0; wr[k] = 1'b1; end
    repeat (2) tick();
    for (int k = 0; k < 2; k++) wr[k] = 1'b0;
    tick();
    for (int k = 0; k < 2; k++) fu[k] = 8'h04;
    repeat (2) tick();
    for (int k = 0; k < 2; k++) fu[k] = 8'h00;

    // Address 3: out of range on the 3-port instance, valid on the 4-port one.
    for (int k = 0; k < 2; k++) begin da[k] = 1'b1; di[k] = 2'd3; wr[k] = 1'b1; end
    tick();
    for (int k = 0; k < 2; k++) begin da[k] = 1'b0; fu[k] = 8'hFF; end
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin da[k] = 1'b1; di[k] = 2'd1; fu[k] = 8'h00; end
    tick();
    for (int k = 0; k < 2; k++) da[k] = 1'b0;
    repeat (2) tick();
    quiet();

    // Continuous stall on port 0: pulses after edges 30 and 60 (every 4 on d1).
    for (int k = 0; k < 2; k++) em[k] = 8'hFE;
    repeat (62) tick();

    // Stall port 1 for 20 edges, read once, then stall again.
    for (int k = 0; k < 2; k++) em[k] = 8'hFD;
    repeat (20) tick();
    for (int k = 0; k < 2; k++) rd[k] = 8'h02;
    tick();
    for (int k = 0; k < 2; k++) rd[k] = 8'h00;
    repeat (32) tick();

    // Port 0 drains at the 29th stalled edge, then stalls again.
    quiet();
    tick();
    for (int k = 0; k < 2; k++) em[k] = 8'hFE;
    repeat (29) tick();
    for (int k = 0; k < 2; k++) em[k] = 8'hFF;
    tick();
    for (int k = 0; k < 2; k++) em[k] = 8'hFE;
    repeat (31) tick();

    // Reset in the middle of a stall.
    quiet();
    tick();
    for (int k = 0; k < 2; k++) em[k] = 8'hFE;
    repeat (15) tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    repeat (31) tick();

    // All ports stalled together.
    for (int k = 0; k < 2; k++) em[k] = 8'h00;
    repeat (10) tick();

    // Biased random traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      rstn = ($urandom_range(0, 199) != 0);
      for (int k = 0; k < 2; k++) rand_inputs(k);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
